// File: rtl/cpu6502_alu_sequencer_pkg.sv
// Shared constants for the 6502 ALU command sequencer: command codes, ALU control codes,
// P bit positions, FSM states and the per-flag update bundle.
package cpu6502_alu_sequencer_pkg;

   localparam logic [7:0] P_RESET_DEFAULT = 8'h34;

   localparam int C_BIT_IN_P = 0;
   localparam int Z_BIT_IN_P = 1;
   localparam int I_BIT_IN_P = 2;
   localparam int D_BIT_IN_P = 3;
   localparam int B_BIT_IN_P = 4;
   localparam int V_BIT_IN_P = 6;
   localparam int N_BIT_IN_P = 7;

   typedef enum logic [3:0] {
      SEQ_OP_ADC    = 4'd0,
      SEQ_OP_SBC    = 4'd1,
      SEQ_OP_AND    = 4'd2,
      SEQ_OP_ORA    = 4'd3,
      SEQ_OP_EOR    = 4'd4,
      SEQ_OP_ASL    = 4'd5,
      SEQ_OP_LSR    = 4'd6,
      SEQ_OP_ROL    = 4'd7,
      SEQ_OP_ROR    = 4'd8,
      SEQ_OP_CMP    = 4'd9,
      SEQ_OP_BIT    = 4'd10,
      SEQ_OP_INC    = 4'd11,
      SEQ_OP_DEC    = 4'd12,
      SEQ_OP_ADD16  = 4'd13,
      SEQ_OP_BRTEST = 4'd14,
      SEQ_OP_RSVD   = 4'd15
   } seq_op_t;

   typedef enum logic [2:0] {
      ALU_OP_ADC = 3'd0,
      ALU_OP_SBC = 3'd1,
      ALU_OP_AND = 3'd2,
      ALU_OP_ORA = 3'd3,
      ALU_OP_EOR = 3'd4,
      ALU_OP_SGL = 3'd5
   } alu_op_t;

   typedef enum logic [2:0] {
      ALU_SOP_ASL    = 3'd0,
      ALU_SOP_LSR    = 3'd1,
      ALU_SOP_ROL    = 3'd2,
      ALU_SOP_ROR    = 3'd3,
      ALU_SOP_TEST_N = 3'd4,
      ALU_SOP_TEST_V = 3'd5,
      ALU_SOP_TEST_C = 3'd6,
      ALU_SOP_TEST_Z = 3'd7
   } alu_sop_t;

   typedef enum logic [1:0] {
      BRSEL_N = 2'd0,
      BRSEL_V = 2'd1,
      BRSEL_C = 2'd2,
      BRSEL_Z = 2'd3
   } br_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC_LO = 2'd1,
      ST_EXEC_HI = 2'd2,
      ST_DONE    = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic n;
      logic v;
      logic z;
      logic c;
   } flags_t;

endpackage

// File: rtl/cpu6502_status_reg.sv
// Processor status register P: whole-register load has priority over per-flag updates,
// bit 5 always reads 1.
module cpu6502_status_reg
   import cpu6502_alu_sequencer_pkg::*;
#(
   parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       p_load,
   input  logic [7:0] p_load_val,
   input  flags_t     flag_we,
   input  flags_t     flag_val,
   output logic [7:0] status_p
);

   always_ff @(posedge clk) begin
      if (reset) begin
         status_p <= P_RESET | 8'h20;
      end else if (p_load) begin
         status_p <= p_load_val | 8'h20;
      end else begin
         if (flag_we.n) status_p[N_BIT_IN_P] <= flag_val.n;
         if (flag_we.v) status_p[V_BIT_IN_P] <= flag_val.v;
         if (flag_we.z) status_p[Z_BIT_IN_P] <= flag_val.z;
         if (flag_we.c) status_p[C_BIT_IN_P] <= flag_val.c;
      end
   end

endmodule

// File: rtl/cpu6502_alu_sequencer.sv
// Command-level 6502 ALU controller: one command per handshake, drives the external ALU,
// owns N/V/Z/C. CPU6502_ALU_SEQ_DECIMAL_EN enables decimal ADC/SBC from P.D.
module cpu6502_alu_sequencer
   import cpu6502_alu_sequencer_pkg::*;
#(
   parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [3:0]  cmdOp,
   input  logic [7:0]  cmdA,
   input  logic [7:0]  cmdB,
   input  logic [7:0]  cmdAHi,
   input  logic        pLoad,
   input  logic [7:0]  pLoadVal,
   output logic [7:0]  statusP,
   output logic [7:0]  aluOperandA,
   output logic [7:0]  aluOperandB,
   output logic        aluCarryIn,
   output logic        aluOverflowIn,
   output logic [2:0]  aluOperation,
   output logic [2:0]  aluOpExtension,
   output logic        aluDecimalMode,
   input  logic [7:0]  aluResult,
   input  logic        aluCarryOut,
   input  logic        aluZero,
   input  logic        aluNegative,
   input  logic        aluOverflowOut,
   input  logic        aluBranchCondition,
   output logic        rspValid,
   output logic [15:0] rspResult,
   output logic        rspTaken,
   output logic        rspPageCross,
   output logic [1:0]  dbgState
);

   seq_state_t state, state_next;
   seq_op_t    op_q;
   logic [7:0] a_q, b_q, ahi_q, res_lo_q, res_hi_q;
   logic       lo_carry_q, taken_q, page_cross_q, accept, dec_arith;
   flags_t     flag_we, flag_val;

   assign cmdReady     = (state == ST_IDLE) || (state == ST_DONE);
   assign accept       = cmdValid && cmdReady;
   assign rspValid     = (state == ST_DONE);
   assign rspResult    = {res_hi_q, res_lo_q};
   assign rspTaken     = taken_q;
   assign rspPageCross = page_cross_q;
   assign dbgState     = state;

`ifdef CPU6502_ALU_SEQ_DECIMAL_EN
   assign dec_arith = statusP[D_BIT_IN_P];
`else
   assign dec_arith = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         op_q         <= SEQ_OP_ADC;
         a_q          <= 8'h00;
         b_q          <= 8'h00;
         ahi_q        <= 8'h00;
         res_lo_q     <= 8'h00;
         res_hi_q     <= 8'h00;
         lo_carry_q   <= 1'b0;
         taken_q      <= 1'b0;
         page_cross_q <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_q  <= seq_op_t'(cmdOp);
            a_q   <= cmdA;
            b_q   <= cmdB;
            ahi_q <= cmdAHi;
         end
         if (state == ST_EXEC_LO) begin
            res_lo_q     <= (op_q == SEQ_OP_RSVD) ? 8'h00 : aluResult;
            res_hi_q     <= 8'h00;
            lo_carry_q   <= aluCarryOut;
            taken_q      <= (op_q == SEQ_OP_BRTEST) && (aluBranchCondition == b_q[0]);
            page_cross_q <= (op_q == SEQ_OP_ADD16) && (aluCarryOut ^ b_q[7]);
         end
         if (state == ST_EXEC_HI) res_hi_q <= aluResult;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (accept) state_next = ST_EXEC_LO;
         ST_EXEC_LO: state_next = (op_q == SEQ_OP_ADD16) ? ST_EXEC_HI : ST_DONE;
         ST_EXEC_HI: state_next = ST_DONE;
         ST_DONE:    state_next = accept ? ST_EXEC_LO : ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // ALU control and flag selection; flags are only written from EXEC_LO
   always_comb begin
      aluOperandA    = 8'h00;
      aluOperandB    = 8'h00;
      aluCarryIn     = 1'b0;
      aluOverflowIn  = 1'b0;
      aluOperation   = ALU_OP_ADC;
      aluOpExtension = ALU_SOP_ASL;
      aluDecimalMode = 1'b0;
      flag_we        = '0;
      flag_val       = '{n: aluNegative, v: aluOverflowOut, z: aluZero, c: aluCarryOut};
      if (state == ST_EXEC_HI) begin
         aluOperandA = ahi_q;
         aluOperandB = {8{b_q[7]}};
         aluCarryIn  = lo_carry_q;
      end else if (state == ST_EXEC_LO) begin
         aluOperandA = a_q;
         aluOperandB = b_q;
         case (op_q)
            SEQ_OP_ADC, SEQ_OP_SBC: begin
               aluOperation   = (op_q == SEQ_OP_ADC) ? ALU_OP_ADC : ALU_OP_SBC;
               aluCarryIn     = statusP[C_BIT_IN_P];
               aluOverflowIn  = statusP[V_BIT_IN_P];
               aluDecimalMode = dec_arith;
               flag_we        = '{n: 1'b1, v: 1'b1, z: 1'b1, c: 1'b1};
            end
            SEQ_OP_AND: begin aluOperation = ALU_OP_AND; flag_we = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0}; end
            SEQ_OP_ORA: begin aluOperation = ALU_OP_ORA; flag_we = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0}; end
            SEQ_OP_EOR: begin aluOperation = ALU_OP_EOR; flag_we = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0}; end
            SEQ_OP_ASL, SEQ_OP_LSR, SEQ_OP_ROL, SEQ_OP_ROR: begin
               aluOperation = ALU_OP_SGL;
               aluCarryIn   = statusP[C_BIT_IN_P];
               case (op_q)
                  SEQ_OP_LSR: aluOpExtension = ALU_SOP_LSR;
                  SEQ_OP_ROL: aluOpExtension = ALU_SOP_ROL;
                  SEQ_OP_ROR: aluOpExtension = ALU_SOP_ROR;
                  default:    aluOpExtension = ALU_SOP_ASL;
               endcase
               flag_we = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b1};
            end
            SEQ_OP_CMP: begin
               aluOperation = ALU_OP_SBC;
               aluCarryIn   = 1'b1;
               flag_we      = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b1};
            end
            SEQ_OP_BIT: begin
               aluOperation = ALU_OP_AND;
               flag_val     = '{n: b_q[7], v: b_q[6], z: aluZero, c: aluCarryOut};
               flag_we      = '{n: 1'b1, v: 1'b1, z: 1'b1, c: 1'b0};
            end
            SEQ_OP_INC, SEQ_OP_DEC: begin
               aluOperation = (op_q == SEQ_OP_INC) ? ALU_OP_ADC : ALU_OP_SBC;
               aluOperandB  = 8'h01;
               aluCarryIn   = (op_q == SEQ_OP_DEC);
               flag_we      = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0};
            end
            SEQ_OP_ADD16: aluOperation = ALU_OP_ADC;
            SEQ_OP_BRTEST: begin
               aluOperandA  = statusP;
               aluOperation = ALU_OP_SGL;
               case (br_sel_t'(b_q[2:1]))
                  BRSEL_N: aluOpExtension = ALU_SOP_TEST_N;
                  BRSEL_V: aluOpExtension = ALU_SOP_TEST_V;
                  BRSEL_C: aluOpExtension = ALU_SOP_TEST_C;
                  default: aluOpExtension = ALU_SOP_TEST_Z;
               endcase
            end
            default: begin
               aluOperandA = 8'h00;
               aluOperandB = 8'h00;
            end
         endcase
      end
   end

   cpu6502_status_reg #(.P_RESET(P_RESET)) u_status_reg (
      .clk        (clk),
      .reset      (reset),
      .p_load     (pLoad),
      .p_load_val (pLoadVal),
      .flag_we    (flag_we),
      .flag_val   (flag_val),
      .status_p   (statusP)
   );

endmodule

// File: tb/tb_cpu6502_alu_sequencer.sv
// Bench for cpu6502_alu_sequencer: behavioural ALU on the alu* ports, an instruction-level
// model of P and responses checked every cycle, plus directed literal checks.
module tb_cpu6502_alu_sequencer;
   import cpu6502_alu_sequencer_pkg::*;

   logic        clk, reset, cmdValid, cmdReady, pLoad;
   logic [3:0]  cmdOp;
   logic [7:0]  cmdA, cmdB, cmdAHi, pLoadVal, statusP;
   logic [7:0]  aluOperandA, aluOperandB, aluResult;
   logic        aluCarryIn, aluOverflowIn, aluDecimalMode;
   logic [2:0]  aluOperation, aluOpExtension;
   logic        aluCarryOut, aluZero, aluNegative, aluOverflowOut, aluBranchCondition;
   logic        rspValid, rspTaken, rspPageCross;
   logic [15:0] rspResult;
   logic [1:0]  dbgState;

   int n_cmp = 0;
   int n_bad = 0;

   cpu6502_alu_sequencer dut (
      .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
      .cmdA(cmdA), .cmdB(cmdB), .cmdAHi(cmdAHi), .pLoad(pLoad), .pLoadVal(pLoadVal),
      .statusP(statusP), .aluOperandA(aluOperandA), .aluOperandB(aluOperandB),
      .aluCarryIn(aluCarryIn), .aluOverflowIn(aluOverflowIn), .aluOperation(aluOperation),
      .aluOpExtension(aluOpExtension), .aluDecimalMode(aluDecimalMode), .aluResult(aluResult),
      .aluCarryOut(aluCarryOut), .aluZero(aluZero), .aluNegative(aluNegative),
      .aluOverflowOut(aluOverflowOut), .aluBranchCondition(aluBranchCondition),
      .rspValid(rspValid), .rspResult(rspResult), .rspTaken(rspTaken),
      .rspPageCross(rspPageCross), .dbgState(dbgState)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic int sx(input logic [7:0] v);
      return v[7] ? int'(v) - 256 : int'(v);
   endfunction

   function automatic logic [8:0] adc9(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic d);
      int lo, hi;
      if (!d) return {1'b0, a} + {1'b0, b} + {8'h00, c};
      lo = int'(a[3:0]) + int'(b[3:0]) + int'(c);
      if (lo > 9) lo = lo + 6;
      hi = int'(a[7:4]) + int'(b[7:4]) + ((lo > 15) ? 1 : 0);
      if (hi > 9) hi = hi + 6;
      return {(hi > 15), 4'(hi), 4'(lo)};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural external ALU ----------------
   logic [8:0] alu_s;
   int         alu_sa;
   always_comb begin
      aluResult = 8'h00; aluCarryOut = 1'b0; aluOverflowOut = 1'b0; aluBranchCondition = 1'b0;
      alu_s = 9'h000; alu_sa = 0;
      case (aluOperation)
         ALU_OP_ADC: begin
            alu_s = adc9(aluOperandA, aluOperandB, aluCarryIn, aluDecimalMode);
            aluResult = alu_s[7:0]; aluCarryOut = alu_s[8];
            alu_sa = sx(aluOperandA) + sx(aluOperandB) + int'(aluCarryIn);
            aluOverflowOut = (alu_sa > 127) || (alu_sa < -128);
         end
         ALU_OP_SBC: begin
            alu_s = {1'b0, aluOperandA} + {1'b0, ~aluOperandB} + {8'h00, aluCarryIn};
            aluResult = alu_s[7:0]; aluCarryOut = alu_s[8];
            alu_sa = sx(aluOperandA) - sx(aluOperandB) - 1 + int'(aluCarryIn);
            aluOverflowOut = (alu_sa > 127) || (alu_sa < -128);
         end
         ALU_OP_AND: aluResult = aluOperandA & aluOperandB;
         ALU_OP_ORA: aluResult = aluOperandA | aluOperandB;
         ALU_OP_EOR: aluResult = aluOperandA ^ aluOperandB;
         ALU_OP_SGL: begin
            case (aluOpExtension)
               3'd0: {aluCarryOut, aluResult} = {aluOperandA, 1'b0};
               3'd1: {aluResult, aluCarryOut} = {1'b0, aluOperandA};
               3'd2: {aluCarryOut, aluResult} = {aluOperandA, aluCarryIn};
               3'd3: {aluResult, aluCarryOut} = {aluCarryIn, aluOperandA};
               3'd4: aluBranchCondition = aluOperandA[7];
               3'd5: aluBranchCondition = aluOperandA[6];
               3'd6: aluBranchCondition = aluOperandA[0];
               default: aluBranchCondition = aluOperandA[1];
            endcase
         end
         default: aluResult = 8'h00;
      endcase
   end
   assign aluZero     = (aluResult == 8'h00);
   assign aluNegative = aluResult[7];

   // ---------------- instruction-level model + scoreboard ----------------
   int          cyc = 0;
   int          m_busy_until = 0;
   int          m_acc = 0;
   bit          m_pend = 0;
   bit          started = 0;
   logic [3:0]  m_op;
   logic [7:0]  m_a, m_b, m_ahi;
   logic [7:0]  m_p = 8'h34;
   logic [49:0] exp_q[$];   // {due cycle, result, taken, page cross}

   task automatic exec_model();
      logic [7:0]  a, b, r, p;
      logic [15:0] res16;
      logic        tk, pc, dec, set_nz, cond;
      logic [8:0]  s;
      int          u, sg, t, due;
      a = m_a; b = m_b; p = m_p; r = 8'h00; res16 = 16'h0000; tk = 0; pc = 0; set_nz = 1;
`ifdef CPU6502_ALU_SEQ_DECIMAL_EN
      dec = p[3];
`else
      dec = 1'b0;
`endif
      case (m_op)
         SEQ_OP_ADC: begin
            u = int'(a) + int'(b) + int'(p[0]);
            sg = sx(a) + sx(b) + int'(p[0]);
            if (dec) begin s = adc9(a, b, p[0], 1'b1); r = s[7:0]; p[0] = s[8]; end
            else begin r = 8'(u); p[0] = (u > 255); end
            p[6] = (sg > 127) || (sg < -128);
         end
         SEQ_OP_SBC: begin
            u = int'(a) - int'(b) - (1 - int'(p[0]));
            sg = sx(a) - sx(b) - (1 - int'(p[0]));
            r = 8'(u); p[0] = (u >= 0); p[6] = (sg > 127) || (sg < -128);
         end
         SEQ_OP_AND: r = a & b;
         SEQ_OP_ORA: r = a | b;
         SEQ_OP_EOR: r = a ^ b;
         SEQ_OP_ASL: begin r = 8'((int'(a) * 2) % 256); p[0] = (a >= 8'd128); end
         SEQ_OP_LSR: begin r = a / 2; p[0] = a[0]; end
         SEQ_OP_ROL: begin r = 8'((int'(a) * 2) % 256 + int'(p[0])); p[0] = (a >= 8'd128); end
         SEQ_OP_ROR: begin r = 8'(int'(a) / 2 + int'(p[0]) * 128); p[0] = a[0]; end
         SEQ_OP_CMP: begin r = 8'(int'(a) - int'(b)); p[0] = (a >= b); end
         SEQ_OP_BIT: begin r = a & b; p[1] = (r == 8'h00); p[7] = b[7]; p[6] = b[6]; set_nz = 0; end
         SEQ_OP_INC: r = 8'(int'(a) + 1);
         SEQ_OP_DEC: r = 8'(int'(a) - 1);
         SEQ_OP_ADD16: begin
            t = int'({m_ahi, a}) + sx(b);
            set_nz = 0;
         end
         SEQ_OP_BRTEST: begin
            case (b[2:1])
               2'd0: cond = p[7];
               2'd1: cond = p[6];
               2'd2: cond = p[0];
               default: cond = p[1];
            endcase
            tk = (cond == b[0]);
            set_nz = 0;
         end
         default: set_nz = 0;
      endcase
      if (set_nz) begin p[7] = r[7]; p[1] = (r == 8'h00); end
      if (m_op == SEQ_OP_ADD16) begin
         res16 = 16'(t);
         pc = (res16[15:8] != m_ahi);
      end else begin
         res16 = {8'h00, r};
      end
      m_p = p;
      due = m_acc + ((m_op == SEQ_OP_ADD16) ? 3 : 2);
      exp_q.push_back({32'(due), res16, tk, pc});
   endtask

   task automatic model_step();
      if (reset) begin
         exp_q.delete();
         m_p = 8'h34; m_busy_until = 0; m_pend = 0; started = 1;
         return;
      end
      if (m_pend && cyc == m_acc + 1) begin
         m_pend = 0;
         exec_model();
      end
      if (pLoad) m_p = pLoadVal | 8'h20;
      if (cmdValid && cyc >= m_busy_until) begin
         m_op = cmdOp; m_a = cmdA; m_b = cmdB; m_ahi = cmdAHi;
         m_acc = cyc; m_pend = 1;
         m_busy_until = cyc + ((cmdOp == SEQ_OP_ADD16) ? 3 : 2);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      model_step();
   end

   task automatic compare();
      logic [49:0] e;
      logic        exp_v;
      if (!started) return;
      check("statusP", statusP, m_p);
      check("cmdReady", cmdReady, (cyc + 1 >= m_busy_until));
      exp_v = (exp_q.size() > 0) && (exp_q[0][49:18] == 32'(cyc + 1));
      check("rspValid", rspValid, exp_v);
      if (exp_v) begin
         e = exp_q.pop_front();
         check("rspResult", rspResult, e[17:2]);
         check("rspTaken", rspTaken, e[1]);
         check("rspPageCross", rspPageCross, e[0]);
      end
      while (exp_q.size() > 0 && exp_q[0][49:18] < 32'(cyc + 1)) void'(exp_q.pop_front());
   endtask

   initial forever begin
      @(negedge clk);
      compare();
   end

   // ---------------- driver ----------------
   task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ahi, input bit pl, input logic [7:0] plv,
                          input bit rst, output logic [15:0] res, output logic tk,
                          output logic pc);
      int n;
      bit got;
      n = 0;
      while (!cmdReady && n < 8) begin @(negedge clk); n++; end
      check("ready_timeout", cmdReady, 1'b1);
      cmdValid = 1'b1; cmdOp = op; cmdA = a; cmdB = b; cmdAHi = ahi;
      @(posedge clk); @(negedge clk);
      cmdValid = 1'b0;
      cmdOp  = 4'($urandom_range(0, 15));
      cmdA   = 8'($urandom_range(0, 255));
      cmdB   = 8'($urandom_range(0, 255));
      cmdAHi = 8'($urandom_range(0, 255));
      pLoad = pl; pLoadVal = plv; reset = rst;
      @(posedge clk); @(negedge clk);
      pLoad = 1'b0; reset = 1'b0;
      got = 0; res = 16'h0000; tk = 1'b0; pc = 1'b0;
      for (int i = 0; i < 3 && !got; i++) begin
         if (rspValid) begin
            got = 1; res = rspResult; tk = rspTaken; pc = rspPageCross;
         end else begin
            @(negedge clk);
         end
      end
      if (rst) check("rst_mid_no_rsp", got, 1'b0);
      else     check("rsp_timeout", got, 1'b1);
   endtask

   task automatic load_p(input logic [7:0] v);
      pLoad = 1'b1; pLoadVal = v;
      @(posedge clk); @(negedge clk);
      pLoad = 1'b0;
   endtask

   logic [15:0] r16;
   logic        tk, pc;

   initial begin
      reset = 1'b1; cmdValid = 1'b0; cmdOp = 4'h0; cmdA = 8'h00; cmdB = 8'h00;
      cmdAHi = 8'h00; pLoad = 1'b0; pLoadVal = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_statusP", statusP, 8'h34);
      check("rst_cmdReady", cmdReady, 1'b1);
      check("rst_rspValid", rspValid, 1'b0);
      check("rst_rspResult", rspResult, 16'h0000);
      check("rst_rspTaken", rspTaken, 1'b0);
      check("rst_rspPageCross", rspPageCross, 1'b0);
      check("rst_aluOperation", aluOperation, 3'd0);
      check("rst_aluOperandA", aluOperandA, 8'h00);
      check("rst_state", dbgState, 2'd0);
      repeat (4) @(negedge clk);

      run_cmd(SEQ_OP_ADC, 8'h50, 8'h50, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("adc_res", r16, 16'h00A0);
      check("adc_p", statusP, 8'hF4);
      run_cmd(SEQ_OP_CMP, 8'h10, 8'h10, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("cmp_res", r16, 16'h0000);
      check("cmp_p", statusP, 8'h77);
      run_cmd(SEQ_OP_ADD16, 8'hF0, 8'h20, 8'h12, 0, 8'h00, 0, r16, tk, pc);
      check("add16_fwd_res", r16, 16'h1310);
      check("add16_fwd_pc", pc, 1'b1);
      run_cmd(SEQ_OP_ADD16, 8'h10, 8'hF0, 8'h12, 0, 8'h00, 0, r16, tk, pc);
      check("add16_back_res", r16, 16'h1200);
      check("add16_back_pc", pc, 1'b0);
      run_cmd(SEQ_OP_ADD16, 8'hFF, 8'h01, 8'hFF, 0, 8'h00, 0, r16, tk, pc);
      check("add16_wrap_res", r16, 16'h0000);
      check("add16_p_held", statusP, 8'h77);
      run_cmd(SEQ_OP_ADC, 8'h01, 8'h01, 8'h00, 1, 8'hFF, 0, r16, tk, pc);
      check("pload_wins_p", statusP, 8'hFF);
      run_cmd(SEQ_OP_BRTEST, 8'h00, 8'h07, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("brtest_z1_taken", tk, 1'b1);
      run_cmd(SEQ_OP_BRTEST, 8'h00, 8'h06, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("brtest_z0_taken", tk, 1'b0);
      run_cmd(SEQ_OP_BIT, 8'h0F, 8'h40, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("bit_p", statusP, 8'h7F);
      run_cmd(SEQ_OP_INC, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("inc_wrap_res", r16, 16'h0000);
      run_cmd(SEQ_OP_DEC, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("dec_wrap_res", r16, 16'h00FF);
      check("dec_p", statusP, 8'hFD);
      run_cmd(SEQ_OP_ASL, 8'h81, 8'h00, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("asl_res", r16, 16'h0002);
      run_cmd(SEQ_OP_ROR, 8'h01, 8'h00, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("ror_res", r16, 16'h0080);
      run_cmd(SEQ_OP_SBC, 8'h50, 8'hF0, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("sbc_res", r16, 16'h0060);
      check("sbc_p", statusP, 8'h3C);
      run_cmd(SEQ_OP_LSR, 8'h03, 8'h00, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      run_cmd(SEQ_OP_ROL, 8'h80, 8'h00, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      run_cmd(SEQ_OP_AND, 8'hF0, 8'h3C, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      run_cmd(SEQ_OP_ORA, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      run_cmd(SEQ_OP_EOR, 8'hAA, 8'h55, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("eor_res", r16, 16'h00FF);
      run_cmd(SEQ_OP_BRTEST, 8'h00, 8'h01, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      run_cmd(SEQ_OP_RSVD, 8'h12, 8'h34, 8'h56, 0, 8'h00, 0, r16, tk, pc);
      check("rsvd_res", r16, 16'h0000);

      load_p(8'h08);
      run_cmd(SEQ_OP_ADC, 8'h09, 8'h01, 8'h00, 0, 8'h00, 0, r16, tk, pc);
`ifdef CPU6502_ALU_SEQ_DECIMAL_EN
      check("decimal_adc", r16, 16'h0010);
`else
      check("decimal_adc", r16, 16'h000A);
`endif
      run_cmd(SEQ_OP_ADC, 8'h11, 8'h22, 8'h00, 0, 8'h00, 1, r16, tk, pc);
      check("rst_mid_p", statusP, 8'h34);
      run_cmd(SEQ_OP_ADC, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 0, r16, tk, pc);
      check("adc_wrap_res", r16, 16'h0000);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
